// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//
// Purpose:
//   Responder side of the instruction-fetch port (port a). A fetch request
//   (read_a/address_a) is captured, held for LATENCY wait states, and then
//   answered with a one-cycle resp_a pulse. The pulse carries the word read
//   from a word-addressed instruction store. A backdoor load port fills the
//   store for simulation and boot.
//
// Optional feature (compile-time macro IMEM_PREFETCH_EN):
//   This adds a one-entry next-word buffer. Every response prefetches the
//   word at req_addr+4. A later capture of that word is answered on the
//   next cycle, whatever LATENCY is.
//
// Parameters:
//   DEPTH_WORDS  store size in 32-bit words (power of two)
//   LATENCY      wait cycles between capture and response (0..15)
//   NOP_WORD     word returned for out-of-range addresses
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   read_a       fetch request valid (may be held high)
//   address_a    fetch byte address, bits [1:0] ignored
//   resp_a       one-cycle pulse: rdata_a valid for the captured address
//   rdata_a      instruction word, holds its value while resp_a is low
//   load_we      backdoor word write enable
//   load_addr    backdoor byte address, bits [1:0] ignored
//   load_wdata   backdoor write data
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_a,
    input  logic [31:0] address_a,
    output logic        resp_a,
    output logic [31:0] rdata_a,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_wdata
);

    localparam int         IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_RELOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Any address bit above the word-index field makes the access out of range.
    function automatic logic in_range(input logic [31:0] addr);
        return (addr >> (IDX_W + 2)) == 32'd0;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return addr[IDX_W+1:2];
    endfunction

    state_t      state;
    state_t      state_nx;
    logic [31:0] req_addr;
    logic [31:0] req_addr_nx;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_nx;
    logic        capture;
    logic        enter_resp;
    logic [31:0] rd_addr;
    logic [31:0] rd_word;
    logic [31:0] resp_word;
    logic        pf_hit;
    logic        load_ok;

    // ---------------------------------------------------------------------
    // Instruction store (not reset; contents are undefined until loaded)
    // ---------------------------------------------------------------------
    logic [31:0] store [DEPTH_WORDS];

    assign load_ok = load_we && in_range(load_addr);

    always_ff @(posedge clk) begin
        if (load_ok) begin
            store[word_idx(load_addr)] <= load_wdata;
        end
    end

    // Write-first read port. A load to the same word on the same edge wins
    // over the stored value.
    always_comb begin
        rd_word = store[word_idx(rd_addr)];
        if (!in_range(rd_addr)) begin
            rd_word = NOP_WORD;
        end else if (load_ok && (word_idx(load_addr) == word_idx(rd_addr))) begin
            rd_word = load_wdata;
        end
    end

    // ---------------------------------------------------------------------
    // Request FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nx    = state;
        req_addr_nx = req_addr;
        wait_cnt_nx = wait_cnt;
        capture     = 1'b0;
        enter_resp  = 1'b0;
        rd_addr     = req_addr;

        case (state)
            ST_IDLE, ST_RESP: begin
                // A request at the edge leaving RESP is a fresh back-to-back capture.
                if (read_a) begin
                    capture = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!read_a) begin
                    state_nx = ST_IDLE;
                end else if (address_a != req_addr) begin
                    capture = 1'b1;
                end else if (wait_cnt == 4'd0) begin
                    state_nx   = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt - 4'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Initial captures and WAIT restarts share one path. A prefetch hit
        // or a zero-latency store goes straight to RESP.
        if (capture) begin
            req_addr_nx = address_a;
            rd_addr     = address_a;
            if (pf_hit || (LATENCY == 0)) begin
                state_nx   = ST_RESP;
                enter_resp = 1'b1;
            end else begin
                state_nx    = ST_WAIT;
                wait_cnt_nx = WAIT_RELOAD;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Request FSM: state and response registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            req_addr <= 32'd0;
            wait_cnt <= 4'd0;
            resp_a   <= 1'b0;
            rdata_a  <= 32'd0;
        end else begin
            state    <= state_nx;
            req_addr <= req_addr_nx;
            wait_cnt <= wait_cnt_nx;
            resp_a   <= enter_resp;
            if (enter_resp) begin
                rdata_a <= resp_word;
            end
        end
    end

`ifdef IMEM_PREFETCH_EN
    // ---------------------------------------------------------------------
    // Next-word prefetch buffer
    // ---------------------------------------------------------------------
    logic        pf_valid;
    logic [31:0] pf_tag;
    logic [31:0] pf_data;
    logic        pf_kill;
    logic [31:0] pf_addr;
    logic [31:0] pf_word;

    // A backdoor write to the buffered word makes the buffered data stale.
    // This applies on the same edge as well, so such a capture takes the
    // normal path and reads the new data write-first.
    assign pf_kill = pf_valid && load_we && (load_addr[31:2] == pf_tag[31:2]);
    assign pf_hit  = pf_valid && !pf_kill && (address_a[31:2] == pf_tag[31:2]);
    assign pf_addr = rd_addr + 32'd4;

    always_comb begin
        pf_word = store[word_idx(pf_addr)];
        if (!in_range(pf_addr)) begin
            pf_word = NOP_WORD;
        end else if (load_ok && (word_idx(load_addr) == word_idx(pf_addr))) begin
            pf_word = load_wdata;
        end
    end

    assign resp_word = (capture && pf_hit) ? pf_data : rd_word;

    // Refill on entry to RESP overrides an invalidation on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_valid <= 1'b0;
        end else if (enter_resp) begin
            pf_valid <= in_range(pf_addr);
        end else if (pf_kill || (capture && !pf_hit)) begin
            pf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp) begin
            pf_tag  <= pf_addr;
            pf_data <= pf_word;
        end
    end
`else
    assign pf_hit    = 1'b0;
    assign resp_word = rd_word;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
//
// Four responders with LATENCY 2, 0, 3 and 4 run side by side, each with its
// own directed stimulus. A transaction-level model tracks every instance:
// each pending request has a due cycle, each instance has a word store, and
// there is an optional next-word buffer. A single compare process checks
// resp_a/rdata_a of every instance on every falling edge. Directed sequences
// add hand-computed literal expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_responder;

    localparam int          NI    = 4;
    localparam int          DEPTH = 1024;
    localparam logic [15:0] LATS  = {4'd4, 4'd3, 4'd0, 4'd2};
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rd     [NI];
    logic [31:0] addr   [NI];
    logic        lwe    [NI];
    logic [31:0] laddr  [NI];
    logic [31:0] lwdata [NI];
    logic        resp   [NI];
    logic [31:0] rdata  [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            imem_responder #(
                .DEPTH_WORDS (DEPTH),
                .LATENCY     (int'(LATS[g*4 +: 4])),
                .NOP_WORD    (NOP)
            ) dut (
                .clk        (clk),
                .rst        (rst),
                .read_a     (rd[g]),
                .address_a  (addr[g]),
                .resp_a     (resp[g]),
                .rdata_a    (rdata[g]),
                .load_we    (lwe[g]),
                .load_addr  (laddr[g]),
                .load_wdata (lwdata[g])
            );
        end
    endgenerate

    task automatic check32(input string name, input int idx,
                           input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h, expected %h", name, idx, got, exp);
        end
    endtask

    task automatic check1(input string name, input int idx, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %b, expected %b", name, idx, got, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model
    // ---------------------------------------------------------------------
    logic        m_busy  [NI];
    logic [31:0] m_addr  [NI];
    int          m_due   [NI];
    logic        m_resp  [NI];
    logic [31:0] m_rdata [NI];
    logic        pf_v    [NI];
    logic [31:0] pf_tag  [NI];
    logic [31:0] pf_dat  [NI];
    logic [31:0] mm      [NI][DEPTH];
    int          cyc;

    function automatic logic in_rng(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    function automatic logic [31:0] word_at(input int g, input logic [31:0] a);
        if (!in_rng(a)) return NOP;
        if (lwe[g] && in_rng(laddr[g]) && (laddr[g] >> 2) == (a >> 2)) return lwdata[g];
        return mm[g][int'(a >> 2)];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0;
            for (int g = 0; g < NI; g++) begin
                m_busy[g]  = 1'b0;
                m_addr[g]  = 32'd0;
                m_due[g]   = 0;
                m_resp[g]  = 1'b0;
                m_rdata[g] = 32'd0;
                pf_v[g]    = 1'b0;
            end
        end else begin
            for (int g = 0; g < NI; g++) begin
                int          lat_g;
                logic        cap;
                logic        go;
                logic        hit;
                logic [31:0] tgt;
                logic [31:0] dnow;
                lat_g = int'(LATS[g*4 +: 4]);
                cap   = 1'b0;
                go    = 1'b0;
                hit   = 1'b0;
                tgt   = 32'd0;
                dnow  = m_rdata[g];
                if (lwe[g] && pf_v[g] && (laddr[g] >> 2) == (pf_tag[g] >> 2)) pf_v[g] = 1'b0;
                if (m_busy[g]) begin
                    if (!rd[g]) begin
                        m_busy[g] = 1'b0;
                    end else if (addr[g] != m_addr[g]) begin
                        cap = 1'b1;
                    end else if (cyc == m_due[g]) begin
                        go        = 1'b1;
                        tgt       = m_addr[g];
                        dnow      = word_at(g, tgt);
                        m_busy[g] = 1'b0;
                    end
                end else if (rd[g]) begin
                    cap = 1'b1;
                end
                if (cap) begin
                    hit       = PF && pf_v[g] && (addr[g] >> 2) == (pf_tag[g] >> 2);
                    m_busy[g] = 1'b0;
                    if (hit) begin
                        go   = 1'b1;
                        tgt  = addr[g];
                        dnow = pf_dat[g];
                    end else begin
                        pf_v[g] = 1'b0;
                        if (lat_g == 0) begin
                            go   = 1'b1;
                            tgt  = addr[g];
                            dnow = word_at(g, tgt);
                        end else begin
                            m_busy[g] = 1'b1;
                            m_addr[g] = addr[g];
                            m_due[g]  = cyc + lat_g;
                        end
                    end
                end
                if (go && PF) begin
                    pf_tag[g] = tgt + 32'd4;
                    pf_v[g]   = in_rng(tgt + 32'd4);
                    pf_dat[g] = word_at(g, tgt + 32'd4);
                end
                m_resp[g]  = go;
                m_rdata[g] = dnow;
                if (lwe[g] && in_rng(laddr[g])) mm[g][int'(laddr[g] >> 2)] = lwdata[g];
            end
            cyc++;
        end
    end

    // Compare every instance against the model on every falling edge.
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            check1("model_resp", g, resp[g], m_resp[g]);
            check32("model_rdata", g, rdata[g], m_rdata[g]);
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int g, input logic [31:0] a, input logic [31:0] d);
        lwe[g]    = 1'b1;
        laddr[g]  = a;
        lwdata[g] = d;
        step();
        lwe[g]    = 1'b0;
    endtask

    // Hold a request until it is answered. lat counts edges from the
    // capture edge (1) to the edge that raised resp_a.
    task automatic measure(input int g, input logic [31:0] a, input int limit,
                           output int lat, output logic [31:0] data);
        rd[g]   = 1'b1;
        addr[g] = a;
        lat     = 0;
        while (lat < limit) begin
            step();
            lat++;
            if (resp[g]) break;
        end
        rd[g] = 1'b0;
        data  = rdata[g];
        if (!resp[g]) begin
            checks++;
            errors++;
            $display("FAIL measure inst%0d addr %h: got no response, expected one within %0d cycles",
                     g, a, limit);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1);
    end

    // ---------------------------------------------------------------------
    // Directed stimulus
    // ---------------------------------------------------------------------
    initial begin
        int          lat;
        int          cnt;
        int          pos;
        logic [31:0] d;
        logic [31:0] stream_exp [3];
        stream_exp = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002};

        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            rd[g]     = 1'b0;
            addr[g]   = 32'd0;
            lwe[g]    = 1'b0;
            laddr[g]  = 32'd0;
            lwdata[g] = 32'd0;
        end
        step();
        step();
        rst = 1'b0;

        // Reset then idle
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check1("idle_resp", 0, resp[0], 1'b0);
            check32("idle_rdata", 0, rdata[0], 32'd0);
            step();
        end

        // Preload
        load(0, 32'h14, 32'hDEAD_BEEF);
        load(1, 32'h0, stream_exp[0]);
        load(1, 32'h4, stream_exp[1]);
        load(1, 32'h8, stream_exp[2]);
        load(2, 32'h20, 32'hA0A0_A0A0);
        load(2, 32'h40, 32'hB0B0_B0B0);
        load(3, 32'h100, 32'h6464_6464);
        load(3, 32'h104, 32'h6565_6565);
        load(3, 32'h108, 32'h6666_6666);

        // Single read, LATENCY=2: resp in cycle N+3
        measure(0, 32'h14, 10, lat, d);
        check32("single_latency", 0, lat, 32'd3);
        check32("single_data", 0, d, 32'hDEAD_BEEF);
        step();
        check1("single_pulse_end", 0, resp[0], 1'b0);
        check32("single_data_hold", 0, rdata[0], 32'hDEAD_BEEF);

        // Continuous fetch, LATENCY=0
        rd[1]   = 1'b1;
        addr[1] = 32'h0;
        for (int k = 0; k < 3; k++) begin
            step();
            addr[1] = 32'((k + 1) * 4);
            @(negedge clk);
            check1("stream_resp", 1, resp[1], 1'b1);
            check32("stream_data", 1, rdata[1], stream_exp[k]);
        end
        rd[1] = 1'b0;
        step();
        @(negedge clk);
        check1("stream_stop", 1, resp[1], 1'b0);
        step();

        // Address change in WAIT, LATENCY=3
        rd[2]   = 1'b1;
        addr[2] = 32'h20;
        step();
        step();
        addr[2] = 32'h40;
        step();
        cnt = 0;
        pos = -1;
        d   = 32'd0;
        for (int k = 0; k < 7; k++) begin
            if (k == 3) rd[2] = 1'b0;
            @(negedge clk);
            if (resp[2]) begin
                cnt++;
                pos = k;
                d   = rdata[2];
            end
            step();
        end
        check32("restart_count", 2, cnt, 32'd1);
        check32("restart_cycle", 2, pos, 32'd3);
        check32("restart_data", 2, d, 32'hB0B0_B0B0);

        // Drop read_a during WAIT: no response
        rd[2]   = 1'b1;
        addr[2] = 32'h20;
        step();
        step();
        rd[2] = 1'b0;
        cnt   = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp[2]) cnt++;
            step();
        end
        check32("abort_count", 2, cnt, 32'd0);

        // Out-of-range read returns NOP
        measure(0, 32'h8000_0000, 10, lat, d);
        check32("oor_data", 0, d, NOP);
        check32("oor_latency", 0, lat, 32'd3);
        step();

        // Write-first on the edge entering RESP
        rd[0]   = 1'b1;
        addr[0] = 32'h14;
        step();
        step();
        lwe[0]    = 1'b1;
        laddr[0]  = 32'h14;
        lwdata[0] = 32'hCAFE_F00D;
        step();
        lwe[0] = 1'b0;
        rd[0]  = 1'b0;
        check1("wfirst_resp", 0, resp[0], 1'b1);
        check32("wfirst_data", 0, rdata[0], 32'hCAFE_F00D);
        step();

        // Out-of-range write is dropped
        load(0, 32'h8000_0014, 32'h1234_5678);
        measure(0, 32'h14, 10, lat, d);
        check32("oor_write_dropped", 0, d, 32'hCAFE_F00D);
        step();

        // Asynchronous reset mid-request
        rd[0]   = 1'b1;
        addr[0] = 32'h14;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check1("async_rst_resp", 0, resp[0], 1'b0);
        check32("async_rst_rdata", 0, rdata[0], 32'd0);
        rd[0] = 1'b0;
        step();
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp[0]) cnt++;
            step();
        end
        check32("rst_no_resp", 0, cnt, 32'd0);

        // Next-word buffer, LATENCY=4
        measure(3, 32'h100, 12, lat, d);
        check32("pf_first_latency", 3, lat, 32'd5);
        check32("pf_first_data", 3, d, 32'h6464_6464);
        measure(3, 32'h104, 12, lat, d);
        check32("pf_next_latency", 3, lat, PF ? 32'd1 : 32'd5);
        check32("pf_next_data", 3, d, 32'h6565_6565);
        step();
        measure(3, 32'h100, 12, lat, d);
        check32("pf_reread_latency", 3, lat, 32'd5);
        step();
        load(3, 32'h104, 32'h0BAD_F00D);
        measure(3, 32'h104, 12, lat, d);
        check32("pf_inval_latency", 3, lat, 32'd5);
        check32("pf_inval_data", 3, d, 32'h0BAD_F00D);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Responder side of the instruction-fetch memory port (port a). It accepts `read_a`/`address_a` from the fetch stage and returns `resp_a` with `rdata_a` after a programmable number of wait states, from a word-addressed instruction store. It sits between fetch and the instruction memory model/cache boundary. A backdoor load port fills the store for simulation and boot.

## Interface
- `DEPTH_WORDS`, 1024: store size in 32-bit words; power of two.
- `LATENCY`, 2: wait cycles between request capture and response; legal range 0..15.
- `NOP_WORD`, 32'h0000_0013: data returned for out-of-range addresses.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `read_a`  in  1  fetch request valid; may be held high continuously.
- `address_a`  in  32  byte address; bits [1:0] ignored.
- `resp_a`  out  1  one-cycle pulse: `rdata_a` valid for the captured address.
- `rdata_a`  out  32  instruction word; holds last value when `resp_a`=0.
- `load_we`  in  1  backdoor word write enable.
- `load_addr`  in  32  backdoor byte address; bits [1:0] ignored.
- `load_wdata`  in  32  backdoor write data.

## Operation
- Word index = addr[log2(DEPTH_WORDS)+1:2]. An address with any bit above that range set is out of range: reads return `NOP_WORD`, and writes are dropped.
- Internal regs: `state`, `req_addr`, `wait_cnt` (4 bits), `rdata_a`, `resp_a`.
- FSM:
  - IDLE: if `read_a`=1 at edge, capture `req_addr`<=`address_a`. If LATENCY=0 go to RESP, otherwise go to WAIT with `wait_cnt`<=LATENCY-1.
  - WAIT:
    - if `read_a`=0 at edge: abort to IDLE, with no response.
    - else if `address_a`!=`req_addr`: restart, recapture the address and reload `wait_cnt`<=LATENCY-1.
    - else if `wait_cnt`=0: go to RESP.
    - else decrement.
  - RESP: `resp_a`=1 for this cycle only. At the leaving edge, if `read_a`=1 treat as IDLE capture (back-to-back requests), else go to IDLE.
- `rdata_a` is loaded at the edge entering RESP from store[`req_addr`] (or the address being captured when LATENCY=0). The store is write-first: a same-edge `load_we` to the same word returns `load_wdata`.
- `load_we` writes at any state. It does not disturb the FSM.
- The store is not reset; contents are X until loaded.

## Timing
- Reset values: `resp_a`=0, `rdata_a`=0, state=IDLE, `req_addr`=0, `wait_cnt`=0, prefetch valid=0.
- Request sampled at edge N with a stable address gives `resp_a` high in cycle N+LATENCY+1 (the cycle after edge N+LATENCY).
- Sustained throughput with `read_a` held and a stable address: one response per LATENCY+1 cycles. LATENCY=0 gives one response per cycle.
- `rst` asserted mid-request clears immediately (asynchronous). No response is issued for the aborted request.
- An address change on the cycle the response is issued has no effect on that response. The new address is captured at the leaving edge.
- A `resp_a` pulse never exceeds 1 cycle per captured request.

## Configuration
- `IMEM_PREFETCH_EN` defined:
  - On every RESP, a one-entry buffer captures tag=`req_addr`+4 and data=store[`req_addr`+4], and is marked valid.
  - A capture whose word address matches a valid tag goes directly to RESP. Its response arrives in the next cycle regardless of LATENCY, with data from the buffer.
  - The buffer is invalidated by reset, by `load_we` to the tagged word, and by any capture that misses.
  - An out-of-range +4 address leaves the buffer invalid.
- Not defined: no buffer; every request takes the full LATENCY.

## Test plan
- Reset then idle: `rst` pulse with `read_a`=0 -> `resp_a`=0, `rdata_a`=0 for 10 cycles.
- Single read, LATENCY=2: load word 5 = 32'hDEAD_BEEF; `address_a`=0x14 with `read_a` pulsed at edge N -> `resp_a`=1 only in cycle N+3, `rdata_a`=32'hDEAD_BEEF.
- Continuous fetch, LATENCY=0, address stepping 0x0, 0x4, 0x8 each cycle -> `resp_a` high every cycle, data = words 0, 1, 2 in order.
- Address change in WAIT, LATENCY=3: request 0x20, switch to 0x40 two cycles later -> exactly one `resp_a`, carrying word 0x40/4, at 4 cycles after the switch edge. Dropping `read_a` in WAIT instead -> no `resp_a`.
- Out of range and write-first: read 0x8000_0000 -> `rdata_a`=32'h0000_0013. A `load_we` to the pending word on the edge entering RESP -> `rdata_a`=`load_wdata`.
- With `IMEM_PREFETCH_EN`, LATENCY=4: read 0x100, then 0x104 -> the second `resp_a` comes 1 cycle after capture. A `load_we` to 0x104 before the second read -> full 5-cycle latency with the new data.
